coin_input_conditioner: RTL
===========================

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles a synchronized input must differ from its debounced level before that level is accepted; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock for all state.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port btn_raw, input, 4 bits: asynchronous raw contacts; bit3 = 5-cent coin, bit2 = 10-cent coin, bit1 = 25-cent coin, bit0 = item_taken; active-high.
REQ-005 The block SHALL have port x, output, 4 bits: registered one-hot event pulse, same bit mapping as btn_raw, fed directly to the vending FSM.
REQ-006 The block SHALL have port coin_reject, output, 1 bit: registered one-cycle pulse flagging simultaneous events that were discarded.

Function
REQ-007 Each btn_raw bit SHALL pass through a two-flop synchronizer (sync1 -> sync2) before any other use.
REQ-008 Each bit SHALL have an independent debounced level deb[i] and a counter cnt[i] of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-009 Per edge: if sync2[i] == deb[i], cnt[i] SHALL clear to 0.
REQ-010 If sync2[i] != deb[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment.
REQ-011 If sync2[i] != deb[i] and cnt[i] == DEBOUNCE_CYCLES-1, deb[i] SHALL take sync2[i] and cnt[i] SHALL clear to 0.
REQ-012 A rise event rise[i] SHALL be flagged only on the edge where deb[i] changes 0->1; a 1->0 change SHALL generate no event.
REQ-013 If exactly one rise[i] is set, x SHALL equal that one-hot code for exactly one cycle on the next edge, and coin_reject SHALL stay 0.
REQ-014 If two or more rise[i] are set on the same edge, x SHALL be 4'b0000, coin_reject SHALL pulse 1 for one cycle, and all those events SHALL be discarded without retry.
REQ-015 If no rise[i] is set, x SHALL be 4'b0000 and coin_reject SHALL be 0.
REQ-016 x SHALL never have more than one bit set, and SHALL never be high for two consecutive cycles.
REQ-017 Latency: btn_raw held at a new value 1 from sampling edge E1 SHALL produce x high between edges E(DEBOUNCE_CYCLES+3) and E(DEBOUNCE_CYCLES+4).
REQ-018 Bounce: any sync2[i] excursion shorter than DEBOUNCE_CYCLES cycles SHALL be ignored, since cnt[i] clears when the input returns.
REQ-019 A contact held high indefinitely SHALL yield exactly one pulse; a new pulse SHALL require deb[i] to first return to 0 (a low of at least DEBOUNCE_CYCLES cycles).
REQ-020 Events on different bits separated by at least one cycle of debounced rise time SHALL each produce their own pulse; no event SHALL be lost.
REQ-021 cnt[i] SHALL saturate logically via REQ-011 and SHALL never wrap.

Reset
REQ-022 While reset_n is 0, sync1, sync2, deb, cnt, x and coin_reject SHALL all be 0 immediately, regardless of clk.
REQ-023 Reset asserted mid-debounce SHALL abort the pending event; no pulse SHALL be emitted for it after release.
REQ-024 A contact already held high at reset release SHALL produce exactly one pulse, DEBOUNCE_CYCLES+3 edges after release.

Verification
REQ-025 Clean press: DEBOUNCE_CYCLES=4, btn_raw=4'b1000 held from edge E1 -> x=4'b1000 exactly during the cycle after E7, otherwise 0; coin_reject stays 0.
REQ-026 Bounce: btn_raw[2] toggles 1,0,1,0 every cycle for 6 cycles, then holds 1 -> exactly one x=4'b0100 pulse, 7 edges after the stable hold begins.
REQ-027 Simultaneous: btn_raw=4'b0110 applied in one step -> x stays 0, and coin_reject=1 for exactly one cycle at edge E7.
REQ-028 Sequence: 25-cent press, released for 10 cycles, then item_taken press -> x=4'b0010 followed later by x=4'b0001, each a single cycle; a long hold produces no repeat.
REQ-029 Reset: assert reset_n=0 at edge E4 of a press, release at E6 with button still held -> outputs 0 during reset, then one pulse at release+7 edges.

Source files
------------

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
//   Conditions four raw, asynchronous, bouncing contacts for the vending FSM.
//   Each contact is synchronized, debounced, and then edge-detected on its
//   0->1 transition. The FSM receives a single-cycle one-hot event on x.
//   If two or more events arrive on the same cycle, all of them are dropped
//   and a single coin_reject pulse is raised instead.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive cycles a synchronized input must
//                     differ from its debounced level before that level
//                     changes (2..65535)
//
// Ports
//   clk         : clock for all state
//   reset_n     : asynchronous, active-low reset
//   btn_raw     : raw contacts, active-high
//                 [3]=5c, [2]=10c, [1]=25c, [0]=item_taken
//   x           : registered one-hot event pulse, same bit mapping as btn_raw
//   coin_reject : registered pulse when simultaneous events were discarded
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] x,
  output logic       coin_reject
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_deb;
  logic [3:0][CW-1:0] r_cnt;
  logic [3:0]         r_rise;

  logic [3:0]         w_deb_nxt;
  logic [3:0][CW-1:0] w_cnt_nxt;
  logic [3:0]         w_rise_nxt;
  logic               w_any_rise;
  logic               w_multi_rise;

  // Per-bit debounce.
  // The counter only advances while the input disagrees with the accepted
  // level. Any agreement clears it, so short glitches never accumulate.
  // Reaching CNT_MAX commits the new level, which keeps the counter from
  // wrapping.
  always_comb begin
    w_deb_nxt  = r_deb;
    w_cnt_nxt  = r_cnt;
    w_rise_nxt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_sync2[i] == r_deb[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_deb_nxt[i]  = r_sync2[i];
        w_cnt_nxt[i]  = '0;
        w_rise_nxt[i] = r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // More than one bit is set exactly when clearing the lowest set bit
  // leaves something behind.
  assign w_any_rise   = |r_rise;
  assign w_multi_rise = |(r_rise & (r_rise - 4'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_deb       <= '0;
      r_cnt       <= '0;
      r_rise      <= '0;
      x           <= '0;
      coin_reject <= 1'b0;
    end else begin
      r_sync1     <= btn_raw;
      r_sync2     <= r_sync1;
      r_deb       <= w_deb_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rise      <= w_rise_nxt;
      x           <= (w_any_rise && !w_multi_rise) ? r_rise : 4'b0000;
      coin_reject <= w_multi_rise;
    end
  end

endmodule
